snitch_regfile_wb_arbiter: RTL
==============================

// Module: snitch_regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port among N_REQ writeback sources (ALU, LSU, accelerator).
//   - Round-robin arbitration with a valid/ready handshake per source.
//   - Registered write stage (rf_we_o / rf_waddr_o / rf_wdata_o) that drives the regfile write port.
//   - Scoreboard of pending destination registers, with hazard flags for the issue stage.
// PARAMETERS
//   N_REQ         2   number of writeback requesters (>=2)
//   DATA_WIDTH    32  register width
//   ADDR_WIDTH    5   register index width; NUM_REGS = 2**ADDR_WIDTH
//   NR_READ_PORTS 2   number of hazard query ports (one per regfile read port)
//   ZERO_REG_ZERO 1   1: register 0 is never written and never marked busy
// PORTS
//   clk_i          in  1                      clock
//   rst_ni         in  1                      asynchronous reset, active-low
//   issue_valid_i  in  1                      an instruction with a destination register issues this cycle
//   issue_rd_i     in  ADDR_WIDTH             destination register of the issuing instruction
//   issue_waw_o    out 1                      issue_rd_i is currently busy; issue stage must stall
//   hz_raddr_i     in  NR_READ_PORTS*AW       source register indices to check
//   hz_busy_o      out NR_READ_PORTS          source register has a pending write (RAW hazard)
//   wb_valid_i     in  N_REQ                  writeback request valid
//   wb_addr_i      in  N_REQ*ADDR_WIDTH       writeback destination register
//   wb_data_i      in  N_REQ*DATA_WIDTH       writeback data
//   wb_ready_o     out N_REQ                  request accepted this cycle
//   rf_we_o        out 1                      regfile write enable
//   rf_waddr_o     out ADDR_WIDTH             regfile write address
//   rf_wdata_o     out DATA_WIDTH             regfile write data
//   sb_busy_o      out NUM_REGS               scoreboard vector (debug/trace)
// BEHAVIOUR
//   Reset
//   - All outputs are 0: rf_we_o, rf_waddr_o, rf_wdata_o, sb_busy_o.
//   - The round-robin pointer resets to requester 0.
//   Arbitration
//   - Combinational. The winner is the first valid requester at or after the pointer, modulo N_REQ.
//   - Exactly the winner sees wb_ready_o=1 in the same cycle. No valid requester means no ready.
//   - On a handshake, the pointer moves to winner+1 (wrapping to 0 after N_REQ-1). Otherwise it holds.
//   - A requester holds valid, addr and data stable until it gets ready.
//   Write stage (latency 1)
//   - A handshake in cycle t gives rf_we_o=1 in t+1, with the winner's addr and data registered.
//   - Without a handshake, rf_we_o=0 in t+1. rf_waddr_o and rf_wdata_o hold their last values.
//   - x0 writeback with ZERO_REG_ZERO=1: the handshake completes (ready=1), but rf_we_o stays 0.
//   Scoreboard (NUM_REGS flops)
//   - Set: issue_valid_i & !issue_waw_o sets bit issue_rd_i. Never set for x0 when ZERO_REG_ZERO=1.
//   - Clear: rf_we_o=1 clears bit rf_waddr_o at the end of the same cycle the regfile is written.
//   - Set and clear on the same index in one cycle: set wins.
//   - issue_waw_o = sb[issue_rd_i].
//   - hz_busy_o[k] = sb[hz_raddr_i[k]].
//   - The arbiter does not check wb_addr_i against the scoreboard. A writeback to a non-busy register
//     is written normally, and its scoreboard bit stays 0.
//   Reset mid-operation
//   - Pending writes are lost and the scoreboard clears. Upstream is reset together with this block.
// CONFIGURATION
//   SNITCH_WB_ARB_BYPASS_EN defined
//   - Adds output ports byp_valid_o[NR_READ_PORTS] and byp_data_o[NR_READ_PORTS*DW].
//   - When rf_we_o=1 and hz_raddr_i[k]==rf_waddr_o (and the index is not x0):
//     byp_valid_o[k]=1, byp_data_o[k]=rf_wdata_o, and hz_busy_o[k] is forced to 0.
//   - The issue stage then consumes the forwarded operand one cycle earlier.
//   SNITCH_WB_ARB_BYPASS_EN undefined
//   - The byp_* ports are absent.
//   - hz_busy_o stays high through the write cycle; the operand is read from the regfile the next cycle.
// STRUCTURE
//   Package snitch_wb_arb_pkg holds:
//   - the wb_req_t struct {addr, data};
//   - the localparam NUM_REGS;
//   - the function rr_next(ptr, valid) that returns the winner index.
//   Sub-module snitch_wb_rr_arb: round-robin arbiter only (valid in, one-hot grant out,
//   pointer register). The top level holds the write stage and the scoreboard.
// TESTING
//   1. Reset (rst_ni=0 mid-traffic)
//      -> rf_we_o=0, sb_busy_o=0 and pointer=0 immediately; the first grant after release goes to req0.
//   2. Issue rd=5, then wb req1 addr=5 data=0xDEAD_BEEF
//      -> wb_ready_o=2'b10 on the request cycle.
//      -> Next cycle: rf_we_o=1, waddr=5, wdata=0xDEADBEEF.
//      -> sb[5]=1 until the end of the write cycle, then 0.
//   3. Both requesters valid continuously, pointer=0
//      -> grants alternate 0,1,0,1; neither requester waits more than one cycle.
//   4. Issue rd=0 with ZERO_REG_ZERO=1, then wb addr=0
//      -> sb[0] stays 0; the handshake completes; rf_we_o stays 0.
//   5. Issue rd=7 in the same cycle rf_we_o clears reg 7 -> sb[7]=1 afterwards (set wins).
//   6. hz_raddr_i[0]=7 during the write of reg 7
//      -> Bypass enabled: byp_valid_o[0]=1, byp_data_o[0]=data, hz_busy_o[0]=0.
//      -> Bypass disabled: hz_busy_o[0]=1.

Source files
------------

// File: rtl/snitch_wb_arb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// The request struct is sized for the default 5-bit index / 32-bit data configuration.
package snitch_wb_arb_pkg;

  localparam int unsigned WbAddrWidth = 5;
  localparam int unsigned WbDataWidth = 32;
  localparam int unsigned NUM_REGS    = 2 ** WbAddrWidth;

  // Upper bound on requesters supported by rr_next.
  localparam int unsigned MaxReq  = 16;
  localparam int unsigned MaxReqW = $clog2(MaxReq);

  typedef struct packed {
    logic [WbAddrWidth-1:0] addr;
    logic [WbDataWidth-1:0] data;
  } wb_req_t;

  // First valid requester at or after ptr, modulo n_req; 0 when none is valid.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input logic [MaxReq-1:0] valid,
                                          input int unsigned n_req);
    int unsigned idx;
    logic        found;
    rr_next = 0;
    found   = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (!found && (i < n_req)) begin
        idx = ptr + i;
        if (idx >= n_req) idx = idx - n_req;
        if (valid[idx[MaxReqW-1:0]]) begin
          rr_next = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/snitch_wb_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after the pointer.
// Every grant is a handshake, so the pointer advances whenever any requester is valid.
module snitch_wb_rr_arb
  import snitch_wb_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] valid_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] win_idx;

  always_comb begin
    win_idx = IdxW'(rr_next(32'(ptr_q), MaxReq'(valid_i), N_REQ));
    gnt_o   = '0;
    ptr_d   = ptr_q;
    if (|valid_i) begin
      gnt_o[win_idx] = 1'b1;
      ptr_d = (win_idx == IdxW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  assign idx_o = win_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/snitch_regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin source select, registered write port, pending-write
// scoreboard. Define SNITCH_WB_ARB_BYPASS_EN to add write-cycle operand forwarding (byp_* ports).
module snitch_regfile_wb_arbiter
  import snitch_wb_arb_pkg::*;
#(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned DATA_WIDTH    = WbDataWidth,
  parameter int unsigned ADDR_WIDTH    = WbAddrWidth,
  parameter int unsigned NR_READ_PORTS = 2,
  parameter bit          ZERO_REG_ZERO = 1'b1,
  localparam int unsigned NumRegs      = 2 ** ADDR_WIDTH
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                issue_valid_i,
  input  logic [ADDR_WIDTH-1:0]               issue_rd_i,
  output logic                                issue_waw_o,
  input  logic [NR_READ_PORTS*ADDR_WIDTH-1:0] hz_raddr_i,
  output logic [NR_READ_PORTS-1:0]            hz_busy_o,
  input  logic [N_REQ-1:0]                    wb_valid_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]         wb_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]         wb_data_i,
  output logic [N_REQ-1:0]                    wb_ready_o,
  output logic                                rf_we_o,
  output logic [ADDR_WIDTH-1:0]               rf_waddr_o,
  output logic [DATA_WIDTH-1:0]               rf_wdata_o,
  output logic [NumRegs-1:0]                  sb_busy_o
`ifdef SNITCH_WB_ARB_BYPASS_EN
  ,
  output logic [NR_READ_PORTS-1:0]            byp_valid_o,
  output logic [NR_READ_PORTS*DATA_WIDTH-1:0] byp_data_o
`endif
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IdxW-1:0]       win_idx;
  logic                  handshake;
  wb_req_t               reqs [N_REQ];
  wb_req_t               sel;
  logic [ADDR_WIDTH-1:0] hz_raddr [NR_READ_PORTS];

  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NumRegs-1:0]    sb_q, sb_d;

  snitch_wb_rr_arb #(
    .N_REQ (N_REQ)
  ) u_rr_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (wb_valid_i),
    .gnt_o   (wb_ready_o),
    .idx_o   (win_idx)
  );

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign reqs[i].addr = wb_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign reqs[i].data = wb_data_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar k = 0; k < NR_READ_PORTS; k++) begin : g_hz
    assign hz_raddr[k] = hz_raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign handshake = |wb_valid_i;

  // Write stage: x0 writebacks still handshake but never raise the write enable.
  always_comb begin
    sel        = reqs[win_idx];
    rf_we_d    = handshake && !(ZERO_REG_ZERO && (sel.addr == '0));
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (handshake) begin
      rf_waddr_d = sel.addr;
      rf_wdata_d = sel.data;
    end
  end

  assign issue_waw_o = sb_q[issue_rd_i];

  // Clear first so a same-cycle set on the same index wins.
  always_comb begin
    sb_d = sb_q;
    if (rf_we_q) sb_d[rf_waddr_q] = 1'b0;
    if (issue_valid_i && !issue_waw_o && !(ZERO_REG_ZERO && (issue_rd_i == '0))) begin
      sb_d[issue_rd_i] = 1'b1;
    end
  end

  always_comb begin
    hz_busy_o = '0;
`ifdef SNITCH_WB_ARB_BYPASS_EN
    byp_valid_o = '0;
    byp_data_o  = '0;
`endif
    for (int k = 0; k < NR_READ_PORTS; k++) begin
      hz_busy_o[k] = sb_q[hz_raddr[k]];
`ifdef SNITCH_WB_ARB_BYPASS_EN
      if (rf_we_q && (hz_raddr[k] == rf_waddr_q) && (hz_raddr[k] != '0)) begin
        byp_valid_o[k]                         = 1'b1;
        byp_data_o[k*DATA_WIDTH +: DATA_WIDTH] = rf_wdata_q;
        hz_busy_o[k]                           = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      sb_q       <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      sb_q       <= sb_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign sb_busy_o  = sb_q;

endmodule
